// File: rtl/mesh_feed_ctrl.sv
// mesh_feed_ctrl: driver side of the 2x2 systolic mesh multiplier.
// Latches a job of two 2x2 matrices, clears the mesh, streams the
// coefficients with the enable schedule the mesh expects, then captures
// the four products and returns them with a one-cycle DONE pulse.
// Optional macro MESH_FEED_BTB_EN: START is also accepted in FIN so
// back-to-back jobs skip the IDLE cycle.
module mesh_feed_ctrl #(
    parameter int DW = 4,
    parameter int RW = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic [4*DW-1:0] A_IN,
    input  logic [4*DW-1:0] B_IN,
    output logic            BUSY,
    output logic            DONE,
    output logic [4*RW-1:0] RES,
    output logic            MESH_RST,
    output logic [DW-1:0]   A00_O,
    output logic [DW-1:0]   A10_O,
    output logic [DW-1:0]   B00_O,
    output logic [DW-1:0]   B01_O,
    output logic            ENP,
    output logic            ENQ,
    output logic [3:0]      ENA,
    output logic [3:0]      ENR,
    input  logic [RW-1:0]   MTX00,
    input  logic [RW-1:0]   MTX01,
    input  logic [RW-1:0]   MTX10,
    input  logic [RW-1:0]   MTX11
);

    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_F0, S_F1, S_D2, S_D3, S_D4, S_CAP, S_FIN
    } state_t;

    state_t state_q, state_d;
    logic   accept;

    logic [4*DW-1:0] a_q, b_q;
    logic [4*RW-1:0] res_q;

    logic            mesh_rst_q, mesh_rst_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [DW-1:0]   a0_q, a0_d, a1_q, a1_d, b0_q, b0_d, b1_q, b1_d;
    logic            enp_q, enp_d, enq_q, enq_d;
    logic [3:0]      ena_q, ena_d, enr_q, enr_d;

    // State register
    always_ff @(posedge CLK) begin
        if (!RST) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; accept marks the cycle where a new job is taken
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: if (START) begin
                state_d = S_CLR;
                accept  = 1'b1;
            end
            S_CLR:  state_d = S_F0;
            S_F0:   state_d = S_F1;
            S_F1:   state_d = S_D2;
            S_D2:   state_d = S_D3;
            S_D3:   state_d = S_D4;
            S_D4:   state_d = S_CAP;
            S_CAP:  state_d = S_FIN;
`ifdef MESH_FEED_BTB_EN
            S_FIN: begin
                if (START) begin
                    state_d = S_CLR;
                    accept  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
`else
            S_FIN:  state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Job operand capture on the accepting edge
    always_ff @(posedge CLK) begin
        if (!RST) begin
            a_q <= '0;
            b_q <= '0;
        end else if (accept) begin
            a_q <= A_IN;
            b_q <= B_IN;
        end
    end

    // Output decode from the upcoming state so registered outputs line up
    // with the state they belong to
    always_comb begin
        mesh_rst_d = 1'b1;
        busy_d     = (state_d != S_IDLE) && (state_d != S_FIN);
        done_d     = 1'b0;
        a0_d       = '0;
        a1_d       = '0;
        b0_d       = '0;
        b1_d       = '0;
        enp_d      = 1'b0;
        enq_d      = 1'b0;
        ena_d      = 4'b0000;
        enr_d      = 4'b0000;
`ifdef MESH_FEED_BTB_EN
        // BUSY is registered, so FIN's value must be chosen one cycle
        // early; START seen during CAP predicts a chained job.
        if (state_d == S_FIN) busy_d = START;
`endif
        case (state_d)
            S_CLR: mesh_rst_d = 1'b0;
            S_F0: begin
                a0_d  = a_q[0*DW +: DW];   // A00
                a1_d  = a_q[2*DW +: DW];   // A10
                b0_d  = b_q[0*DW +: DW];   // B00
                b1_d  = b_q[1*DW +: DW];   // B01
                enp_d = 1'b1;
                ena_d = 4'b0001;
            end
            S_F1: begin
                a0_d  = a_q[1*DW +: DW];   // A01
                a1_d  = a_q[3*DW +: DW];   // A11
                b0_d  = b_q[2*DW +: DW];   // B10
                b1_d  = b_q[3*DW +: DW];   // B11
                enp_d = 1'b1;
                enq_d = 1'b1;
                ena_d = 4'b0111;
            end
            S_D2: begin
                enq_d = 1'b1;
                ena_d = 4'b1110;
                enr_d = 4'b0001;
            end
            S_D3: begin
                ena_d = 4'b1000;
                enr_d = 4'b0110;
            end
            S_D4:  enr_d  = 4'b1000;
            S_FIN: done_d = 1'b1;
            default: ;
        endcase
    end

    // Registered mesh drive and handshake outputs
    always_ff @(posedge CLK) begin
        if (!RST) begin
            mesh_rst_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            a0_q       <= '0;
            a1_q       <= '0;
            b0_q       <= '0;
            b1_q       <= '0;
            enp_q      <= 1'b0;
            enq_q      <= 1'b0;
            ena_q      <= 4'b0000;
            enr_q      <= 4'b0000;
        end else begin
            mesh_rst_q <= mesh_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            a0_q       <= a0_d;
            a1_q       <= a1_d;
            b0_q       <= b0_d;
            b1_q       <= b1_d;
            enp_q      <= enp_d;
            enq_q      <= enq_d;
            ena_q      <= ena_d;
            enr_q      <= enr_d;
        end
    end

    // Result capture at the end of CAP; held until the next job's CAP
    always_ff @(posedge CLK) begin
        if (!RST)                 res_q <= '0;
        else if (state_q == S_CAP) res_q <= {MTX11, MTX10, MTX01, MTX00};
    end

    assign MESH_RST = mesh_rst_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign RES      = res_q;
    assign A00_O    = a0_q;
    assign A10_O    = a1_q;
    assign B00_O    = b0_q;
    assign B01_O    = b1_q;
    assign ENP      = enp_q;
    assign ENQ      = enq_q;
    assign ENA      = ena_q;
    assign ENR      = enr_q;

endmodule

// File: tb/tb_mesh_feed_ctrl.sv
// Self-checking bench for mesh_feed_ctrl with a behavioural mesh model.
module tb_mesh_feed_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [15:0] A_IN, B_IN;
    logic        BUSY, DONE, MESH_RST, ENP, ENQ;
    logic [31:0] RES;
    logic [3:0]  A00_O, A10_O, B00_O, B01_O, ENA, ENR;
    logic [7:0]  mtx [4];

    mesh_feed_ctrl #(.DW(4), .RW(8)) dut (
        .CLK(CLK), .RST(RST), .START(START), .A_IN(A_IN), .B_IN(B_IN),
        .BUSY(BUSY), .DONE(DONE), .RES(RES), .MESH_RST(MESH_RST),
        .A00_O(A00_O), .A10_O(A10_O), .B00_O(B00_O), .B01_O(B01_O),
        .ENP(ENP), .ENQ(ENQ), .ENA(ENA), .ENR(ENR),
        .MTX00(mtx[0]), .MTX01(mtx[1]), .MTX10(mtx[2]), .MTX11(mtx[3])
    );

    always #5 CLK = ~CLK;

    // Mesh model: records one coefficient slot per ENP cycle since the
    // last mesh reset; a MAC's result register loads its dot product on ENR.
    logic [3:0] sa0 [2], sa1 [2], sb0 [2], sb1 [2];
    int mk;

    function automatic logic [7:0] dot(logic [3:0] x0, logic [3:0] x1,
                                       logic [3:0] y0, logic [3:0] y1);
        int s;
        s = int'(x0) * int'(y0) + int'(x1) * int'(y1);
        return 8'(s % 256);
    endfunction

    always @(posedge CLK) begin
        if (MESH_RST !== 1'b1) begin
            mk <= 0;
            for (int i = 0; i < 4; i++) mtx[i] <= 8'h00;
            for (int i = 0; i < 2; i++) begin
                sa0[i] <= 4'h0; sa1[i] <= 4'h0; sb0[i] <= 4'h0; sb1[i] <= 4'h0;
            end
        end else begin
            if (ENP === 1'b1 && mk < 2) begin
                sa0[mk] <= A00_O; sa1[mk] <= A10_O;
                sb0[mk] <= B00_O; sb1[mk] <= B01_O;
                mk <= mk + 1;
            end
            if (ENR[0]) mtx[0] <= dot(sa0[0], sa0[1], sb0[0], sb0[1]);
            if (ENR[1]) mtx[1] <= dot(sa0[0], sa0[1], sb1[0], sb1[1]);
            if (ENR[2]) mtx[2] <= dot(sa1[0], sa1[1], sb0[0], sb0[1]);
            if (ENR[3]) mtx[3] <= dot(sa1[0], sa1[1], sb1[0], sb1[1]);
        end
    end

    int done_cnt = 0;
    always @(posedge CLK) if (DONE === 1'b1) done_cnt <= done_cnt + 1;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference product: C = A * B mod 256, entries indexed i*2+j
    function automatic logic [31:0] matmul(logic [15:0] a, logic [15:0] b);
        int ma [2][2], mb [2][2];
        logic [31:0] r;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                ma[i][j] = int'(a[(i*2+j)*4 +: 4]);
                mb[i][j] = int'(b[(i*2+j)*4 +: 4]);
            end
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                r[(i*2+j)*8 +: 8] = 8'((ma[i][0]*mb[0][j] + ma[i][1]*mb[1][j]) % 256);
        return r;
    endfunction

    function automatic logic [12:0] ctl();
        return {MESH_RST, BUSY, DONE, ENP, ENQ, ENA, ENR};
    endfunction

    // {MESH_RST,BUSY,DONE,ENP,ENQ,ENA,ENR} by cycle offset after accept; 0 = IDLE
    logic [12:0] ctl_tab [9];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] res;
        string       tag;
    } vec_t;
    vec_t vt [3];

    logic [31:0] prev_res = 32'h0;

    // One job: START for one cycle, check every cycle through IDLE return.
    // With intrude set, a second START with other operands lands in F1.
    task automatic run_job(input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] exp, input string tag, input bit intrude);
        int cnt0;
        logic [15:0] s_exp;
        @(negedge CLK);
        cnt0 = done_cnt;
        START = 1'b1; A_IN = a; B_IN = b;
        for (int off = 1; off <= 9; off++) begin
            @(negedge CLK);
            if (off == 1) begin
                START = 1'b0; A_IN = 16'hxxxx; B_IN = 16'hxxxx;
            end
            if (intrude && off == 3) begin
                START = 1'b1; A_IN = ~a; B_IN = a ^ b;
            end
            if (intrude && off == 4) START = 1'b0;
            chk($sformatf("%s ctl off%0d", tag, off), 64'(ctl()), 64'(ctl_tab[off % 9]));
            if (off == 2)      s_exp = {a[3:0], a[11:8], b[3:0], b[7:4]};
            else if (off == 3) s_exp = {a[7:4], a[15:12], b[11:8], b[15:12]};
            else               s_exp = 16'h0;
            if (off <= 4) chk($sformatf("%s streams off%0d", tag, off),
                              64'({A00_O, A10_O, B00_O, B01_O}), 64'(s_exp));
            if (off == 7) chk({tag, " res hold"}, 64'(RES), 64'(prev_res));
            if (off == 8) chk({tag, " res"}, 64'(RES), 64'(exp));
        end
        chk({tag, " idle res"}, 64'(RES), 64'(exp));
        chk({tag, " done count"}, 64'(done_cnt - cnt0), 64'd1);
        prev_res = exp;
    endtask

    initial begin
        logic [15:0] ra, rb;
        int t, d1, d2, lows, cnt0;

        ctl_tab[0] = 13'b1_0_0_0_0_0000_0000;
        ctl_tab[1] = 13'b0_1_0_0_0_0000_0000;
        ctl_tab[2] = 13'b1_1_0_1_0_0001_0000;
        ctl_tab[3] = 13'b1_1_0_1_1_0111_0000;
        ctl_tab[4] = 13'b1_1_0_0_1_1110_0001;
        ctl_tab[5] = 13'b1_1_0_0_0_1000_0110;
        ctl_tab[6] = 13'b1_1_0_0_0_0000_1000;
        ctl_tab[7] = 13'b1_1_0_0_0_0000_0000;
        ctl_tab[8] = 13'b1_0_1_0_0_0000_0000;

        vt[0] = '{16'h4321, 16'h8765, 32'h322B1613, "basic"};
        vt[1] = '{16'hFFFF, 16'hFFFF, 32'hC2C2C2C2, "overflow"};
        vt[2] = '{16'h1001, 16'h3219, 32'h03020109, "identity"};

        // Reset held for three edges
        RST = 1'b0; START = 1'b0; A_IN = 16'h0; B_IN = 16'h0;
        repeat (3) @(negedge CLK);
        chk("reset ctl", 64'(ctl()), 64'd0);
        chk("reset streams", 64'({A00_O, A10_O, B00_O, B01_O}), 64'd0);
        chk("reset res", 64'(RES), 64'd0);
        RST = 1'b1;
        @(negedge CLK);
        chk("post-reset ctl", 64'(ctl()), 64'(ctl_tab[0]));

        // Directed vector table
        for (int i = 0; i < 3; i++) run_job(vt[i].a, vt[i].b, vt[i].res, vt[i].tag, 1'b0);

        // START while busy is ignored
        run_job(16'h2A5C, 16'h9E13, matmul(16'h2A5C, 16'h9E13), "busy-start", 1'b1);
        repeat (12) @(negedge CLK);
        chk("busy-start busy", 64'(BUSY), 64'd0);
        chk("busy-start res", 64'(RES), 64'(matmul(16'h2A5C, 16'h9E13)));

        // Reset during F1 aborts the job
        cnt0 = done_cnt;
        START = 1'b1; A_IN = 16'h7777; B_IN = 16'h5555;
        @(negedge CLK);
        START = 1'b0;
        repeat (2) @(negedge CLK);
        chk("abort in F1", 64'(ctl()), 64'(ctl_tab[3]));
        RST = 1'b0;
        @(negedge CLK);
        chk("abort ctl", 64'(ctl()), 64'd0);
        chk("abort streams", 64'({A00_O, A10_O, B00_O, B01_O}), 64'd0);
        RST = 1'b1;
        repeat (12) @(negedge CLK);
        chk("abort no done", 64'(done_cnt - cnt0), 64'd0);
        chk("abort res cleared", 64'(RES), 64'd0);
        prev_res = 32'h0;
        run_job(16'h1001, 16'h3219, 32'h03020109, "after-abort", 1'b0);

        // Randomized jobs against the reference product
        for (int i = 0; i < 16; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i == 0) begin ra = 16'hF0F0; rb = 16'h0F0F; end
            run_job(ra, rb, matmul(ra, rb), $sformatf("rand%0d", i), 1'b0);
        end

        // START held high: DONE spacing and BUSY gaps
        @(negedge CLK);
        START = 1'b1; A_IN = 16'h4321; B_IN = 16'h8765;
        t = 0; d1 = -1; d2 = -1; lows = 0;
        while (d2 < 0 && t < 40) begin
            @(negedge CLK);
            t++;
            if (DONE === 1'b1) begin
                if (d1 < 0) d1 = t;
                else        d2 = t;
            end
            if (d1 >= 0 && d2 < 0 && BUSY !== 1'b1) lows++;
        end
        START = 1'b0;
        chk("b2b two dones seen", 64'(d2 >= 0), 64'd1);
`ifdef MESH_FEED_BTB_EN
        chk("b2b period", 64'(d2 - d1), 64'd8);
        chk("b2b busy gaps", 64'(lows), 64'd0);
`else
        chk("b2b period", 64'(d2 - d1), 64'd9);
        chk("b2b busy gaps", 64'(lows), 64'd2);
`endif
        chk("b2b res", 64'(RES), 64'h322B1613);
        repeat (20) @(negedge CLK);
        chk("b2b drained", 64'(BUSY), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
